// File: rtl/result_unloader.sv
// result_unloader
//   Unloads the 3x3 MAC result array of the memory bank as a row-major
//   valid/ready stream once the bank signals multiply-complete.
//
//   Ports
//     clk        : single clock, rising edge
//     rst        : asynchronous active-high reset
//     unload_res : multiply-complete level from the memory bank
//     mac_res    : nine DW-bit results, element (r,c) at [(3r+c)*DW +: DW]
//     row_w      : result row count (0 = empty, 1..3)
//     col_x      : result column count (0 = empty, 1..3)
//     data_out   : current result element (registered)
//     out_valid  : data_out holds a valid element (registered)
//     out_ready  : downstream accept; transfer when out_valid & out_ready
//     busy       : high in CAPTURE and SEND
//     done       : one-cycle pulse when unloading completes
module result_unloader #(
    parameter int DW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              unload_res,
    input  logic [9*DW-1:0]   mac_res,
    input  logic [1:0]        row_w,
    input  logic [1:0]        col_x,
    output logic [DW-1:0]     data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE,
        WAIT_LOW
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            unload_q;
    logic            armed;
    logic            rise_q;

    logic [DW-1:0]   snap [9];
    logic [1:0]      rows;
    logic [1:0]      cols;
    logic [1:0]      r;
    logic [1:0]      c;
    logic [1:0]      nr;
    logic [1:0]      nc;
    logic [3:0]      nidx;
    logic            last;
    logic            xfer;

    // Rising-edge detect of unload_res, registered so the edge costs one
    // cycle before CAPTURE. 'armed' stays low for the first clock after
    // reset so a level already high at release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unload_q <= 1'b0;
            armed    <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            unload_q <= unload_res;
            armed    <= 1'b1;
            rise_q   <= armed & unload_res & ~unload_q;
        end
    end

    // Row-major counter advance and element index 3*nr + nc
    always_comb begin
        xfer = out_valid & out_ready;
        last = (r == rows - 2'd1) && (c == cols - 2'd1);
        if (c == cols - 2'd1) begin
            nc = 2'd0;
            nr = r + 2'd1;
        end else begin
            nc = c + 2'd1;
            nr = r;
        end
        nidx = {1'b0, nr, 1'b0} + {2'b00, nr} + {2'b00, nc};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rise_q) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = (row_w != 2'd0 && col_x != 2'd0) ? SEND : DONE;
            SEND:     if (xfer && last) state_nxt = DONE;
            DONE:     state_nxt = WAIT_LOW;
            WAIT_LOW: if (!unload_res) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state == CAPTURE) || (state == SEND);
        done = (state == DONE);
    end

    // Snapshot, counters and registered output stage. The first element is
    // loaded straight from mac_res in CAPTURE (the same sample the snapshot
    // takes) so out_valid rises on the first SEND cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) snap[i] <= '0;
            rows      <= '0;
            cols      <= '0;
            r         <= '0;
            c         <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    for (int unsigned i = 0; i < 9; i++) snap[i] <= mac_res[i*DW +: DW];
                    rows <= row_w;
                    cols <= col_x;
                    r    <= '0;
                    c    <= '0;
                    if (row_w != 2'd0 && col_x != 2'd0) begin
                        out_valid <= 1'b1;
                        data_out  <= mac_res[DW-1:0];
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            out_valid <= 1'b0;
                        end else begin
                            r        <= nr;
                            c        <= nc;
                            data_out <= snap[nidx];
                        end
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;

    localparam int DW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              unload_res;
    logic [9*DW-1:0]   mac_res;
    logic [1:0]        row_w;
    logic [1:0]        col_x;
    logic [DW-1:0]     data_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    result_unloader #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .unload_res (unload_res),
        .mac_res    (mac_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_mac(input int base, input int step);
        for (int i = 0; i < 9; i++) mac_res[i*DW +: DW] = DW'(base + i*step);
    endtask

    // Raise unload_res, collect the stream and compare it against exp_q.
    // Cycle index cyc counts falling edges after the sampling edge, so the
    // first valid element is expected at cyc 2.
    task automatic run_unload(input logic [1:0] rr, input logic [1:0] cc,
                              input bit bp, input bit corrupt, input string name);
        int k = 0;
        int dones = 0;
        int done_cyc = -1;
        int first_valid = -1;
        int last_xfer = -1;
        bit stalled = 1'b0;
        logic [DW-1:0] held = '0;
        @(negedge clk);
        row_w = rr;
        col_x = cc;
        out_ready = 1'b1;
        unload_res = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
            if (corrupt && cyc == 4) begin
                set_mac(1023, 0);
                row_w = 2'd0;
                col_x = 2'd0;
            end
            if (cyc == 0) check({name, " busy_before_capture"}, busy, 0);
            if (cyc == 1) check({name, " busy_capture"}, busy, 1);
            if (stalled) check({name, " stall_hold"}, {out_valid, data_out}, {1'b1, held});
            stalled = 1'b0;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    if (k < exp_q.size())
                        check($sformatf("%s elem%0d", name, k), data_out, exp_q[k]);
                    else
                        check($sformatf("%s extra_elem", name), k, exp_q.size());
                    k++;
                    last_xfer = cyc;
                end else begin
                    stalled = 1'b1;
                    held = data_out;
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                unload_res = 1'b0;
            end
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        check({name, " elem_count"}, k, exp_q.size());
        check({name, " done_pulses"}, dones, 1);
        check({name, " first_valid_cyc"}, first_valid, (exp_q.size() > 0) ? 2 : -1);
        check({name, " done_cyc"}, done_cyc, (exp_q.size() > 0) ? last_xfer + 1 : 2);
        unload_res = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int seen;
        int xfers;
        rst = 1'b1;
        unload_res = 1'b1;
        row_w = 2'd3;
        col_x = 2'd3;
        out_ready = 1'b1;
        set_mac(1, 1);
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // Level already high at reset release must not start an unload
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy || done) seen++;
        end
        check("level_at_release_ignored", seen, 0);
        unload_res = 1'b0;
        repeat (2) @(negedge clk);

        set_mac(1, 1);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_unload(2'd3, 2'd3, 1'b0, 1'b0, "3x3");

        set_mac(10, 10);
        exp_q = '{10, 20, 30, 40, 50, 60};
        run_unload(2'd2, 2'd3, 1'b1, 1'b0, "2x3_bp");

        set_mac(100, 1);
        exp_q = '{100, 101};
        run_unload(2'd1, 2'd2, 1'b0, 1'b0, "1x2");

        set_mac(100, 1);
        exp_q = '{100, 103, 106};
        run_unload(2'd3, 2'd1, 1'b0, 1'b0, "3x1");

        set_mac(100, 1);
        exp_q = {};
        run_unload(2'd0, 2'd2, 1'b0, 1'b0, "empty");

        set_mac(1, 1);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_unload(2'd3, 2'd3, 1'b1, 1'b1, "snapshot");

        set_mac(1023, 0);
        exp_q = '{1023, 1023};
        run_unload(2'd2, 2'd1, 1'b0, 1'b0, "max_val");

        // Reset after four transfers of a 3x3, then restart from (0,0)
        set_mac(1, 1);
        @(negedge clk);
        row_w = 2'd3;
        col_x = 2'd3;
        unload_res = 1'b1;
        xfers = 0;
        for (int cyc = 0; cyc < 20 && xfers < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) xfers++;
        end
        check("abort_xfers_seen", xfers, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_data_out", data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        unload_res = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) seen++;
        end
        check("abort_no_done", seen, 0);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_unload(2'd3, 2'd3, 1'b0, 1'b0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
